mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum active edges in ACCESS without dmem_ack before the access is abandoned.
REQ-002 clk  input  1  pipeline clock; all state updates on the falling edge, matching the pipeline registers.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 MemWriteM  input  1  store request for the instruction in Memory stage.
REQ-005 ResultSrcM  input  2  result select; 2'b01 marks a load.
REQ-006 funct3M  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 ALUResultM  input  32  byte address.
REQ-008 WriteDataM  input  32  store data, right-aligned.
REQ-009 StallM  output  1  holds the F/D/E/M pipeline registers while high.
REQ-010 ReadDataM  output  32  aligned, extended load data.
REQ-011 MisalignM  output  1  one-cycle pulse on a misaligned access.
REQ-012 BusErrM  output  1  one-cycle pulse on bus timeout.
REQ-013 dmem_req  output  1  bus request.
REQ-014 dmem_we  output  1  bus write enable.
REQ-015 dmem_addr  output  32  word address, bits [1:0] = 0.
REQ-016 dmem_be  output  4  byte enables.
REQ-017 dmem_wdata  output  32  lane-replicated store data.
REQ-018 dmem_rdata  input  32  bus read data, valid with dmem_ack.
REQ-019 dmem_ack  input  1  bus completion, sampled on the falling edge.

Function
REQ-020 An access is pending when (MemWriteM or ResultSrcM==2'b01) and funct3M is a legal code; MemWriteM has priority if both are set.
REQ-021 FSM states: IDLE, ACCESS, DONE.
REQ-022 IDLE with an aligned pending access: StallM=1 combinationally; the next edge enters ACCESS and latches address, we, be and wdata.
REQ-023 ACCESS: dmem_req=1 and StallM=1; dmem_addr, dmem_we, dmem_be and dmem_wdata stay stable until dmem_ack is sampled.
REQ-024 ACCESS with dmem_ack=1 at an edge: latch dmem_rdata, go to DONE, and drop dmem_req on that edge.
REQ-025 DONE: StallM=0 and ReadDataM valid for exactly one cycle; the next edge returns to IDLE, and the pipeline advances on that same edge.
REQ-026 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-027 On misalignment: no bus request, MisalignM=1 and StallM=0 for that cycle, store suppressed, ReadDataM=0, FSM stays in IDLE.
REQ-028 Illegal funct3 (011, 110, 111): no access, no flags, ReadDataM=0.
REQ-029 SB: be = 4'b0001<<addr[1:0], wdata = byte replicated x4.
REQ-030 SH: be = 4'b0011<<(2*addr[1]), wdata = half replicated x2.
REQ-031 SW: be = 4'b1111.
REQ-032 Loads: select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-033 Loads drive dmem_be = 4'b1111 on the bus.
REQ-034 An 8-bit counter clears on entry to ACCESS and increments on each ACCESS edge without ack.
REQ-035 When the counter reaches TIMEOUT-1 without ack: drop dmem_req and go to DONE with BusErrM=1 and ReadDataM=0.
REQ-036 dmem_ack sampled outside ACCESS is ignored.
REQ-037 Inputs are ignored while in ACCESS.

Reset
REQ-038 While reset=0: state IDLE, counter 0, and StallM, MisalignM, BusErrM, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ReadDataM all 0.
REQ-039 The first falling edge after reset release only clears an internal flush flag; no access is issued and StallM=0 during that cycle.
REQ-040 Reset asserted mid-ACCESS drops dmem_req immediately; the abandoned access is never completed or retried.

Verification
REQ-041 LW, addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> StallM high 4 cycles, then DONE with ReadDataM=0xDEADBEEF for 1 cycle.
REQ-042 LB addr 0x103 and LBU addr 0x103, rdata 0x80112233 -> ReadDataM=0xFFFFFF80 and 0x00000080 respectively.
REQ-043 SH addr 0x206, WriteDataM 0x1234ABCD, ack after 1 cycle -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_addr=0x204.
REQ-044 SW addr 0x102 -> MisalignM pulses 1 cycle, dmem_req stays 0, StallM stays 0.
REQ-045 LW with ack never asserted, TIMEOUT=16 -> dmem_req high 16 cycles, BusErrM pulse, ReadDataM=0, StallM released.
REQ-046 Reset pulsed low during ACCESS -> dmem_req=0 asynchronously; after release, the first edge issues nothing even with a pending LW.

Source files
------------

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Memory-stage load/store unit. Turns the Memory-stage instruction
//            into a single request/ack data-bus transaction, stalls the
//            pipeline while the bus is busy, aligns and extends load data,
//            replicates store data across byte lanes, flags misaligned
//            accesses and abandons bus accesses that never complete.
//            All state updates occur on the falling edge of clk.
// Ports    : clk, reset (async, active low)
//            MemWriteM, ResultSrcM, funct3M, ALUResultM, WriteDataM
//                                              - Memory-stage instruction
//            StallM, ReadDataM, MisalignM, BusErrM
//                                              - pipeline-facing results
//            dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
//            dmem_rdata, dmem_ack                - data bus
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ACCESS   = 2'd1;
    localparam logic [1:0] c_DONE     = 2'd2;
    localparam logic [1:0] c_RES_LOAD = 2'b01;
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_flush;
    logic [7:0]  r_cnt;
    logic [29:0] r_waddr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;
    logic        r_buserr;

    logic        w_legal;
    logic        w_pending;
    logic        w_misalign;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        w_legal = 1'b0;
        case (funct3M)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
            default:                                w_legal = 1'b0;
        endcase
    end

    assign w_size = funct3M[1:0];

    // The cycle right after reset release never starts an access.
    assign w_pending = (MemWriteM || (ResultSrcM == c_RES_LOAD)) && w_legal && !r_flush;

    assign w_misalign = ((w_size == 2'b01) && ALUResultM[0]) ||
                        ((w_size == 2'b10) && (ALUResultM[1:0] != 2'b00));

    // Store lane placement; loads always read the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        if (MemWriteM) begin
            case (w_size)
                2'b00: begin
                    w_be    = 4'b0001 << ALUResultM[1:0];
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = WriteDataM;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension, using the size/offset captured at
    // the start of the access (pipeline inputs are not trusted meanwhile)
    // ------------------------------------------------------------------
    always_comb begin
        case (r_off)
            2'd0:    w_lane_b = dmem_rdata[7:0];
            2'd1:    w_lane_b = dmem_rdata[15:8];
            2'd2:    w_lane_b = dmem_rdata[23:16];
            default: w_lane_b = dmem_rdata[31:24];
        endcase
        w_lane_h = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_f3)
            3'b000:  w_load = {{24{w_lane_b[7]}}, w_lane_b};
            3'b001:  w_load = {{16{w_lane_h[15]}}, w_lane_h};
            3'b010:  w_load = dmem_rdata;
            3'b100:  w_load = {24'd0, w_lane_b};
            3'b101:  w_load = {16'd0, w_lane_h};
            default: w_load = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and combinational handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        StallM      = 1'b0;
        MisalignM   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_pending) begin
                    if (w_misalign) begin
                        // Let the faulting instruction flow on unstalled.
                        MisalignM = 1'b1;
                    end else begin
                        StallM      = 1'b1;
                        w_state_nxt = c_ACCESS;
                    end
                end
            end
            c_ACCESS: begin
                StallM = 1'b1;
                if (dmem_ack || (r_cnt == c_CNT_LAST)) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                // Pipeline advances on the edge that returns us to IDLE.
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers (falling edge, async active-low reset)
    // ------------------------------------------------------------------
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_flush  <= 1'b1;
            r_cnt    <= '0;
            r_waddr  <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_f3     <= '0;
            r_off    <= '0;
            r_rdata  <= '0;
            r_buserr <= 1'b0;
        end else if (r_flush) begin
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (w_state_nxt == c_ACCESS) begin
                        r_waddr  <= ALUResultM[31:2];
                        r_we     <= MemWriteM;
                        r_be     <= w_be;
                        r_wdata  <= w_wdata;
                        r_f3     <= funct3M;
                        r_off    <= ALUResultM[1:0];
                        r_cnt    <= '0;
                        r_rdata  <= '0;
                        r_buserr <= 1'b0;
                    end
                end
                c_ACCESS: begin
                    // An ack on the final allowed edge still completes.
                    if (dmem_ack) begin
                        r_rdata  <= r_we ? '0 : w_load;
                        r_buserr <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rdata  <= '0;
                        r_buserr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dmem_req   = (r_state == c_ACCESS);
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_waddr, 2'b00};
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign ReadDataM  = (r_state == c_DONE) ? r_rdata : '0;
    assign BusErrM    = (r_state == c_DONE) && r_buserr;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. Directed vector table,
//            reset sequences and randomized transactions checked against an
//            arithmetic reference model of the load/store rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int TMO = 16;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM;
    logic        BusErrM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = no access, 1 = misaligned, 2 = bus access
    // dly : ACCESS cycle in which ack is given (0 = never, i.e. timeout)
    typedef struct {
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          dly;
        logic [31:0] rdata;
        int          kind;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        berr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd, input int dly,
                                input logic [31:0] rdata, input int kind, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] rd, input logic berr);
        vec_t v;
        v.mw = mw; v.rs = rs; v.f3 = f3; v.addr = addr; v.wd = wd; v.dly = dly;
        v.rdata = rdata; v.kind = kind; v.be = be; v.wdata = wdata; v.rd = rd; v.berr = berr;
        return v;
    endfunction

    // Reference model: expected results from the load/store rules alone.
    function automatic vec_t model(input vec_t v);
        vec_t        e;
        int          size;
        int          off;
        logic        legal;
        logic [31:0] val;
        logic [31:0] mask;
        e       = v;
        size    = 1 << int'(v.f3[1:0]);
        off     = int'(v.addr[1:0]);
        legal   = (v.f3 != 3'b011) && (v.f3 != 3'b110) && (v.f3 != 3'b111);
        e.be    = 4'hF;
        e.wdata = '0;
        e.rd    = '0;
        e.berr  = 1'b0;
        if (!((v.mw || v.rs == 2'b01) && legal)) e.kind = 0;
        else if ((off % size) != 0)              e.kind = 1;
        else                                     e.kind = 2;
        if (v.mw) begin
            e.be = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = v.wd[8*(i % size) +: 8];
        end
        if (v.dly == 0) begin
            e.berr = 1'b1;
        end else if (!v.mw) begin
            val = v.rdata >> (8 * off);
            if (size < 4) begin
                mask = (32'h1 << (8 * size)) - 32'h1;
                val  = val & mask;
                if (!v.f3[2] && val[8*size-1]) val = val | ~mask;
            end
            e.rd = val;
        end
        return e;
    endfunction

    task automatic drive_instr(input vec_t v);
        MemWriteM  = v.mw;
        ResultSrcM = v.rs;
        funct3M    = v.f3;
        ALUResultM = v.addr;
        WriteDataM = v.wd;
    endtask

    task automatic drive_idle();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        funct3M    = 3'b010;
        ALUResultM = '0;
        WriteDataM = '0;
    endtask

    // One instruction from presentation in IDLE through DONE, checked every cycle.
    task automatic run_txn(input vec_t v, input string tag);
        int n_acc;
        @(negedge clk); #1;
        drive_instr(v);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        @(posedge clk);
        chk({tag, ".stall0"}, {31'd0, StallM}, {31'd0, v.kind == 2});
        chk({tag, ".misalign0"}, {31'd0, MisalignM}, {31'd0, v.kind == 1});
        chk({tag, ".req0"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, ".buserr0"}, {31'd0, BusErrM}, 32'd0);
        if (v.kind != 2) begin
            chk({tag, ".rdata0"}, ReadDataM, 32'd0);
            return;
        end
        n_acc = (v.dly == 0) ? TMO : v.dly;
        for (int k = 1; k <= n_acc; k++) begin
            @(negedge clk); #1;
            // Pipeline inputs are don't-care while the access is in flight.
            MemWriteM  = 1'($urandom);
            ResultSrcM = 2'($urandom);
            funct3M    = 3'($urandom);
            ALUResultM = $urandom;
            WriteDataM = $urandom;
            dmem_ack   = (k == v.dly);
            dmem_rdata = (k == v.dly) ? v.rdata : $urandom;
            @(posedge clk);
            chk($sformatf("%s.req[%0d]", tag, k), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("%s.stall[%0d]", tag, k), {31'd0, StallM}, 32'd1);
            chk($sformatf("%s.flags[%0d]", tag, k), {30'd0, MisalignM, BusErrM}, 32'd0);
            chk($sformatf("%s.addr[%0d]", tag, k), dmem_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("%s.we[%0d]", tag, k), {31'd0, dmem_we}, {31'd0, v.mw});
            chk($sformatf("%s.be[%0d]", tag, k), {28'd0, dmem_be}, {28'd0, v.be});
            if (v.mw) chk($sformatf("%s.wdata[%0d]", tag, k), dmem_wdata, v.wdata);
        end
        @(negedge clk); #1;
        drive_instr(v);
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        @(posedge clk);
        chk({tag, ".done.stall"}, {31'd0, StallM}, 32'd0);
        chk({tag, ".done.req"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, ".done.buserr"}, {31'd0, BusErrM}, {31'd0, v.berr});
        if (!v.mw || v.berr) chk({tag, ".done.rdata"}, ReadDataM, v.rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[18];
        vec_t v;
        vec_t lw;

        tbl[0]  = mk(0, 2'b01, 3'b010, 32'h100, 32'h0,        3,  32'hDEADBEEF, 2, 4'hF, 32'h0,        32'hDEADBEEF, 0);
        tbl[1]  = mk(0, 2'b01, 3'b000, 32'h103, 32'h0,        1,  32'h80112233, 2, 4'hF, 32'h0,        32'hFFFFFF80, 0);
        tbl[2]  = mk(0, 2'b01, 3'b100, 32'h103, 32'h0,        1,  32'h80112233, 2, 4'hF, 32'h0,        32'h00000080, 0);
        tbl[3]  = mk(1, 2'b00, 3'b001, 32'h206, 32'h1234ABCD, 1,  32'h0,        2, 4'hC, 32'hABCDABCD, 32'h0,        0);
        tbl[4]  = mk(1, 2'b00, 3'b010, 32'h102, 32'h55,       1,  32'h0,        1, 4'hF, 32'h0,        32'h0,        0);
        tbl[5]  = mk(0, 2'b01, 3'b010, 32'h100, 32'h0,        0,  32'h0,        2, 4'hF, 32'h0,        32'h0,        1);
        tbl[6]  = mk(0, 2'b01, 3'b011, 32'h103, 32'h0,        1,  32'h0,        0, 4'hF, 32'h0,        32'h0,        0);
        tbl[7]  = mk(1, 2'b00, 3'b000, 32'h101, 32'h123456A5, 1,  32'h0,        2, 4'h2, 32'hA5A5A5A5, 32'h0,        0);
        tbl[8]  = mk(0, 2'b01, 3'b001, 32'h102, 32'h0,        2,  32'h80017FFF, 2, 4'hF, 32'h0,        32'hFFFF8001, 0);
        tbl[9]  = mk(0, 2'b01, 3'b101, 32'h102, 32'h0,        2,  32'h80017FFF, 2, 4'hF, 32'h0,        32'h00008001, 0);
        tbl[10] = mk(0, 2'b01, 3'b001, 32'h101, 32'h0,        1,  32'h0,        1, 4'hF, 32'h0,        32'h0,        0);
        tbl[11] = mk(1, 2'b00, 3'b010, 32'h10C, 32'hCAFEF00D, 2,  32'h0,        2, 4'hF, 32'hCAFEF00D, 32'h0,        0);
        tbl[12] = mk(0, 2'b00, 3'b010, 32'h100, 32'h0,        1,  32'h0,        0, 4'hF, 32'h0,        32'h0,        0);
        tbl[13] = mk(1, 2'b01, 3'b010, 32'h020, 32'h11223344, 1,  32'h0,        2, 4'hF, 32'h11223344, 32'h0,        0);
        tbl[14] = mk(0, 2'b01, 3'b010, 32'h3FC, 32'h0,        16, 32'h0BADF00D, 2, 4'hF, 32'h0,        32'h0BADF00D, 0);
        tbl[15] = mk(1, 2'b00, 3'b111, 32'h000, 32'h0,        1,  32'h0,        0, 4'hF, 32'h0,        32'h0,        0);
        tbl[16] = mk(0, 2'b01, 3'b000, 32'h100, 32'h0,        1,  32'h0000007F, 2, 4'hF, 32'h0,        32'h0000007F, 0);
        tbl[17] = mk(1, 2'b00, 3'b001, 32'h200, 32'hFFFF8001, 1,  32'h0,        2, 4'h3, 32'h80018001, 32'h0,        0);

        lw = mk(0, 2'b01, 3'b010, 32'h40, 32'h0, 1, 32'h01020304, 2, 4'hF, 32'h0, 32'h01020304, 0);

        // Reset state with a load already pending on the inputs.
        reset      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hFFFFFFFF;
        drive_instr(lw);
        repeat (2) @(negedge clk);
        @(posedge clk);
        chk("rst.outs", {28'd0, StallM, MisalignM, BusErrM, dmem_req}, 32'd0);
        chk("rst.we_be", {27'd0, dmem_we, dmem_be}, 32'd0);
        chk("rst.addr", dmem_addr, 32'd0);
        chk("rst.wdata", dmem_wdata, 32'd0);
        chk("rst.rdata", ReadDataM, 32'd0);

        // First cycle after release issues nothing.
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        chk("flush.stall", {31'd0, StallM}, 32'd0);
        chk("flush.req", {31'd0, dmem_req}, 32'd0);
        run_txn(lw, "post_rst_lw");

        // Directed table.
        for (int i = 0; i < 18; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted in the middle of an access.
        @(negedge clk); #1;
        drive_instr(lw);
        dmem_ack = 1'b0;
        @(posedge clk);
        chk("mid.stall_idle", {31'd0, StallM}, 32'd1);
        @(negedge clk); #1;
        @(posedge clk);
        chk("mid.req_access", {31'd0, dmem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid.req_async", {31'd0, dmem_req}, 32'd0);
        chk("mid.stall_async", {31'd0, StallM}, 32'd0);
        @(negedge clk); #1;
        reset      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        @(posedge clk);
        chk("mid.flush_req", {31'd0, dmem_req}, 32'd0);
        chk("mid.flush_stall", {31'd0, StallM}, 32'd0);
        chk("mid.flush_rdata", ReadDataM, 32'd0);
        @(negedge clk); #1;
        drive_idle();
        dmem_ack = 1'b0;
        @(posedge clk);
        chk("mid.after_req", {31'd0, dmem_req}, 32'd0);
        chk("mid.after_done", {31'd0, StallM, BusErrM}, 32'd0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 80; i++) begin
            v.mw    = 1'($urandom);
            v.rs    = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom);
            v.f3    = 3'($urandom);
            v.addr  = $urandom;
            v.wd    = $urandom;
            v.dly   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
            v.rdata = $urandom;
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        // One idle cycle: no pulse may linger.
        @(negedge clk); #1;
        drive_idle();
        dmem_ack = 1'b1;
        @(posedge clk);
        chk("final.idle", {28'd0, StallM, MisalignM, BusErrM, dmem_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
